serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial subtractor: computes `a - b` one bit per clock, LSB first, using a single borrow flip-flop. It returns a (WIDTH+1)-bit two's-complement difference whose MSB is the borrow. It is the counterpart of the combinational adder example and follows the same operand and result widths. It sits beside the adder in the arithmetic examples and trades latency for area through a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥ 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only while `busy` = 0.
- `a`  in  WIDTH  minuend; sampled on the edge that accepts `start`.
- `b`  in  WIDTH  subtrahend; sampled on the same edge as `a`.
- `busy`  out  1  high while a subtraction is in progress.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  WIDTH+1  `{borrow, diff}`; equals `a - b` mod 2^(WIDTH+1).

## Operation
- States:
  - IDLE: the reset state.
  - SHIFT: subtraction in progress.
  - DONE: result just completed.
- Internal registers:
  - `ra`, `rb`: WIDTH-bit operand shift registers.
  - `rd`: WIDTH-bit difference shift register.
  - `brw`: 1-bit borrow.
  - `cnt`: bit counter, `$clog2(WIDTH+1)` bits wide.
- IDLE or DONE, `start` = 1:
  - Load `ra` ← `a`, `rb` ← `b`, `brw` ← 0, `cnt` ← 0.
  - Go to SHIFT.
- IDLE, `start` = 0: stay in IDLE.
- DONE, `start` = 0: go to IDLE.
- SHIFT, each cycle:
  - `d = ra[0] ^ rb[0] ^ brw`.
  - `brw ← (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw)`.
  - `rd ← {d, rd[WIDTH-1:1]}`.
  - Shift `ra` and `rb` right by 1; `cnt ← cnt + 1`.
- SHIFT, when `cnt` = WIDTH-1:
  - Transfer to DONE.
  - Load `result ← {brw_next, rd_next}` on the same edge.
- `busy` = 1 in SHIFT only. `done` = 1 in DONE only; both are decoded from the state register.
- `result` holds its value until the next completion. It is not cleared by `start`.
- `start` while `busy` = 1 is ignored; `a` and `b` are don't-care then.
- Reset values, asserted asynchronously by `rst_n` = 0:
  - State = IDLE.
  - `busy` = 0, `done` = 0, `result` = 0.
  - `ra`, `rb`, `rd`, `brw`, `cnt` = 0.
- Reset mid-operation: the in-flight operation is discarded and `done` never pulses for it.

## Timing
- Edge E0 accepts `start`. `busy` rises after E0.
- Edges E1…E_WIDTH perform the WIDTH shift steps. State becomes DONE after E_WIDTH.
- `done` and valid `result` appear in the cycle after E_WIDTH, i.e. WIDTH cycles after the accepting edge.
- Back-to-back operation: `start` held high is re-accepted in the DONE cycle.
- Throughput is one result per WIDTH+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_SUB_SATURATE_EN`.
- Defined:
  - When the final borrow is 1, `result[WIDTH-1:0]` is forced to 0 on the completion edge.
  - `result[WIDTH]` still reports the borrow (1).
  - Non-borrow results are unchanged.
- Undefined: `result` is the plain wrapped two's-complement difference.

## Test plan
- Reset, then `a`=8'h55, `b`=8'h33, `start` pulse → `busy` for 8 cycles; `done` pulse 8 cycles after the accepting edge; `result`=9'h022.
- `a`=8'h33, `b`=8'h55 → `result`=9'h1DE without the macro; 9'h100 with `SERIAL_SUB_SATURATE_EN`.
- `a`=8'hFF, `b`=8'hFF → 9'h000. Then `a`=8'h00, `b`=8'h01 → 9'h1FF (9'h100 saturated).
- `start` pulsed with `a`=8'h01, `b`=8'h01 while busy on 8'hF0−8'h0F → ignored; `result`=9'h0E1; exactly one `done` pulse.
- `start` held high continuously with `a`=8'h73, `b`=8'hBA → a `done` pulse every 9 cycles, each with `result`=9'h1B9.
- `rst_n` low for 1 cycle at step 4 of an operation → outputs go to 0 immediately, no `done` pulse; a following 8'h10−8'h01 gives 9'h00F.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b one bit per clock, LSB first, with a single borrow flop.
// Optional SERIAL_SUB_SATURATE_EN clamps the low WIDTH bits of a borrowing result to zero.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             brw_q, brw_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   result_q, result_d;

    logic             d_bit;
    logic             brw_next;
    logic [WIDTH-1:0] rd_next;

    always_comb begin
        d_bit    = ra_q[0] ^ rb_q[0] ^ brw_q;
        brw_next = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & brw_q);
        rd_next  = {d_bit, rd_q[WIDTH-1:1]};

        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rd_d     = rd_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                rd_d  = rd_next;
                brw_d = brw_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d  = StDone;
`ifdef SERIAL_SUB_SATURATE_EN
                    // A borrow means the true difference is negative: clamp to zero magnitude.
                    result_d = brw_next ? {1'b1, {WIDTH{1'b0}}} : {1'b0, rd_next};
`else
                    result_d = {brw_next, rd_next};
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rd_q     <= rd_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StShift);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_serial_sub.sv
// Randomized self-checking bench for serial_sub against an arithmetic reference model.
// Honours SERIAL_SUB_SATURATE_EN when the same macro is defined for the build.
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W:0]   result;

    int n_cmp = 0;
    int n_err = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: full-width modular difference, optionally clamped on borrow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] diff;
        diff = {1'b0, x} - {1'b0, y};
`ifdef SERIAL_SUB_SATURATE_EN
        if (diff[W]) diff = {1'b1, {W{1'b0}}};
`endif
        return diff;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; inject_at >= 0 pulses a stray start(1,1) that many cycles into SHIFT.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input int inject_at);
        int         cycles;
        int         extra_dones;
        logic [W:0] exp;
        exp   = ref_sub(op_a, op_b);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        check("busy_rise", busy, 1);
        cycles = 0;
        while (!done && cycles < 4 * W) begin
            if (cycles == inject_at) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h01;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
            if (!done) check("busy_hold", busy, 1);
        end
        start = 1'b0;
        check("latency", cycles, W);
        check("done_high", done, 1);
        check("busy_in_done", busy, 0);
        check("result", result, exp);
        tick();
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("result_hold", result, exp);
        if (inject_at >= 0) begin
            extra_dones = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done) extra_dones++;
            end
            check("inject_no_extra_done", extra_dones, 0);
            check("inject_result", result, exp);
        end
    endtask

    initial begin
        int         last;
        int         npulse;
        int         spurious;
        int         guard;
        logic [W:0] exp_b2b;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Directed cases
        run_op(8'h55, 8'h33, -1);
        check("dir_55_33", result, 9'h022);
        run_op(8'h33, 8'h55, -1);
        run_op(8'hFF, 8'hFF, -1);
        check("dir_ff_ff", result, 9'h000);
        run_op(8'h00, 8'h01, -1);
        run_op(8'hF0, 8'h0F, 3);
        check("dir_f0_0f", result, 9'h0E1);

        // start held high: re-accepted in every DONE cycle
        exp_b2b = ref_sub(8'h73, 8'hBA);
        a      = 8'h73;
        b      = 8'hBA;
        start  = 1'b1;
        last   = -1;
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) begin
                check("b2b_result", result, exp_b2b);
                if (last >= 0) check("b2b_period", c - last, W + 1);
                last = c;
                npulse++;
            end
        end
        check("b2b_count", npulse, 4);
        start = 1'b0;
        guard = 0;
        while ((busy || done) && guard < 4 * W) begin
            tick();
            guard++;
        end
        check("b2b_drain", {busy, done}, 0);

        // Reset during step 4 of an operation
        a     = 8'hC3;
        b     = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        @(negedge clk) rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) spurious++;
        end
        check("midrst_no_done", spurious, 0);
        run_op(8'h10, 8'h01, -1);
        check("dir_10_01", result, 9'h00F);

        // Random operands
        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? 2 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
